multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have ports, one per line, as follows:
  clk  in  1  single clock; all state changes on rising edge
  rst  in  1  synchronous, active-high reset
  opcode  in  7  instruction [6:0], from the instruction register
  funct3  in  3  instruction [14:12]
  funct7_5  in  1  instruction bit 30
  zero  in  1  ALU zero flag (res == 0)
  neg  in  1  ALU sign flag; unused, ignored
  alu_func  out  4  ALU op: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6
  alu_src_a  out  2  0=PC, 1=old_pc, 2=rs1 reg, 3=zero
  alu_src_b  out  2  0=rs2 reg, 1=imm, 2=const 4
  result_src  out  2  0=alu_out reg, 1=mem data reg, 2=ALU res direct
  imm_src  out  3  I=0, S=1, B=2, J=3, U=4
  adr_src  out  1  memory address: 0=PC, 1=result
  ir_write, pc_write, reg_write, mem_write  out  1 each  write enables
  illegal  out  1  one-cycle pulse on an unsupported opcode

Function
REQ-002 SHALL be a Moore FSM; outputs SHALL be combinational from state plus instruction fields; fields not listed for a state SHALL be 0.
REQ-003 imm_src SHALL decode from opcode in every state: lw/addi-class/jalr=I, sw=S, branch=B, jal=J, lui=U, other=I.
REQ-004 FETCH: adr_src=0, ir_write=1, src_a=PC, src_b=4, ADD, result_src=2, pc_write=1 -> DECODE.
REQ-005 DECODE: src_a=old_pc, src_b=imm, ADD (branch/jal target into alu_out). Next state: R(0110011)->EXEC_R; I(0010011)->EXEC_I; lw(0000011)/sw(0100011)->MEM_ADR; branch(1100011)->BRANCH; jal(1101111)->JAL; jalr(1100111)->JALR; lui(0110111)->LUI; other->FETCH with illegal=1.
REQ-006 EXEC_R: src_a=rs1, src_b=rs2, func per REQ-014 -> ALU_WB. EXEC_I: src_a=rs1, src_b=imm, func per REQ-014 with SUB disabled -> ALU_WB.
REQ-007 ALU_WB: result_src=0, reg_write=1 -> FETCH.
REQ-008 MEM_ADR: src_a=rs1, src_b=imm, ADD -> MEM_READ for lw, MEM_WRITE for sw.
REQ-009 MEM_READ: adr_src=1, result_src=0 -> MEM_WB. MEM_WB: result_src=1, reg_write=1 -> FETCH. MEM_WRITE: adr_src=1, result_src=0, mem_write=1 -> FETCH.
REQ-010 BRANCH: src_a=rs1, src_b=rs2, result_src=0, pc_write=taken -> FETCH. funct3 000/001 SHALL use SUB, 100/101 SLT, 110/111 SLTU.
REQ-011 taken: beq=zero, bne=!zero, blt=!zero, bge=zero, bltu=!zero, bgeu=zero. funct3 010/011 SHALL give not-taken, ADD, illegal=1.
REQ-012 JAL: result_src=0, pc_write=1 -> LINK. JALR: src_a=rs1, src_b=imm, ADD, result_src=2, pc_write=1 -> LINK. LINK: src_a=old_pc, src_b=4, ADD, result_src=2, reg_write=1 -> FETCH.
REQ-013 LUI: src_a=zero, src_b=imm, ADD, result_src=2, reg_write=1 -> FETCH.
REQ-014 funct3 decode: 000 -> SUB if funct7_5 (R only) else ADD; 100 XOR; 110 OR; 111 AND; 010 SLT; 011 SLTU; 001/101 ADD.
REQ-015 Latency SHALL be: R/I 4 cycles, lw 5, sw 4, branch 3, jal/jalr 4, lui 3, illegal 2.

Reset
REQ-016 rst high at a clock edge SHALL force state to FETCH, overriding any transition, including mid-instruction.
REQ-017 While rst is high, ir_write, pc_write, reg_write, mem_write and illegal SHALL be 0.
REQ-018 The first FETCH SHALL be the cycle after rst deasserts.

Structure
REQ-019 A shared package SHALL hold the ALU func codes, the state encoding, and the src_a, src_b, result_src and imm_src encodings; the ALU SHALL use the same func constants.
REQ-020 The funct3/funct7_5 -> alu_func mapping SHALL be a combinational sub-module alu_decoder.

Verification
REQ-021 add (opcode 0110011, f3 000, f7_5 0) after reset -> FETCH, DECODE, EXEC_R (func 0), ALU_WB with reg_write=1 in cycle 4.
REQ-022 sub (f7_5 1) -> EXEC_R func=1. addi with bit 30 set -> func=0.
REQ-023 beq, zero=1 -> BRANCH with func=1, pc_write=1. bgeu, zero=0 -> func=6, pc_write=0. Both return to FETCH.
REQ-024 lw -> five states ending MEM_WB (result_src=1, reg_write=1). sw -> MEM_WRITE with mem_write=1 and adr_src=1.
REQ-025 Opcode 0000000 -> illegal=1 for one cycle in DECODE, then FETCH; no write enable asserted in DECODE.
REQ-026 rst asserted during MEM_READ -> FETCH the next cycle, with mem_write and reg_write never asserted.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RISC-V controller: ALU func codes, FSM states,
// datapath mux selects and the immediate-format decode used in every state.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6
    } alu_func_t;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADR, S_MEM_READ,
        S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_JAL, S_JALR, S_LINK, S_LUI
    } state_t;

    typedef enum logic [1:0] {
        SRCA_PC = 2'd0, SRCA_OLDPC = 2'd1, SRCA_RS1 = 2'd2, SRCA_ZERO = 2'd3
    } src_a_t;

    typedef enum logic [1:0] {
        SRCB_RS2 = 2'd0, SRCB_IMM = 2'd1, SRCB_FOUR = 2'd2
    } src_b_t;

    typedef enum logic [1:0] {
        RES_ALUOUT = 2'd0, RES_MEMDATA = 2'd1, RES_ALU = 2'd2
    } result_src_t;

    typedef enum logic [2:0] {
        IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4
    } imm_src_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    function automatic imm_src_t imm_decode(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            OP_LUI:    return IMM_U;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction fields and ALU flags in, control strobes out.
interface multicycle_controller_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       neg;
    logic [3:0] alu_func;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [2:0] imm_src;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
    logic       illegal;

    modport master (
        input  opcode, funct3, funct7_5, zero, neg,
        output alu_func, alu_src_a, alu_src_b, result_src, imm_src, adr_src,
               ir_write, pc_write, reg_write, mem_write, illegal
    );

    modport slave (
        output opcode, funct3, funct7_5, zero, neg,
        input  alu_func, alu_src_a, alu_src_b, result_src, imm_src, adr_src,
               ir_write, pc_write, reg_write, mem_write, illegal
    );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// funct3/funct7_5 to ALU op for register and immediate arithmetic.
module alu_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       sub_en,
    output alu_func_t  alu_func
);
    always_comb begin
        alu_func = ALU_ADD;
        case (funct3)
            3'b000:  alu_func = (sub_en && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b100:  alu_func = ALU_XOR;
            3'b110:  alu_func = ALU_OR;
            3'b111:  alu_func = ALU_AND;
            3'b010:  alu_func = ALU_SLT;
            3'b011:  alu_func = ALU_SLTU;
            default: alu_func = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing a multicycle RV32 datapath; outputs depend on state and
// instruction fields only, with write strobes forced low while in reset.
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input logic                     clk,
    input logic                     rst,
    multicycle_controller_if.master bus
);
    state_t      state, state_nx;
    alu_func_t   dec_func, func;
    src_a_t      src_a;
    src_b_t      src_b;
    result_src_t res;
    logic        adr, irw, pcw, rw, mw, ill;
    logic        unused_neg;

    assign unused_neg = bus.neg;

    alu_decoder u_alu_dec (
        .funct3   (bus.funct3),
        .funct7_5 (bus.funct7_5),
        .sub_en   (state == S_EXEC_R),
        .alu_func (dec_func)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        func     = ALU_ADD;
        src_a    = SRCA_PC;
        src_b    = SRCB_RS2;
        res      = RES_ALUOUT;
        adr      = 1'b0;
        irw      = 1'b0;
        pcw      = 1'b0;
        rw       = 1'b0;
        mw       = 1'b0;
        ill      = 1'b0;
        case (state)
            S_FETCH: begin
                irw = 1'b1; src_b = SRCB_FOUR; res = RES_ALU; pcw = 1'b1;
                state_nx = S_DECODE;
            end
            S_DECODE: begin
                // speculative branch/jal target lands in alu_out
                src_a = SRCA_OLDPC; src_b = SRCB_IMM;
                case (bus.opcode)
                    OP_R:               state_nx = S_EXEC_R;
                    OP_I:               state_nx = S_EXEC_I;
                    OP_LOAD, OP_STORE:  state_nx = S_MEM_ADR;
                    OP_BRANCH:          state_nx = S_BRANCH;
                    OP_JAL:             state_nx = S_JAL;
                    OP_JALR:            state_nx = S_JALR;
                    OP_LUI:             state_nx = S_LUI;
                    default: begin
                        ill = 1'b1; state_nx = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                src_a = SRCA_RS1; func = dec_func; state_nx = S_ALU_WB;
            end
            S_EXEC_I: begin
                src_a = SRCA_RS1; src_b = SRCB_IMM; func = dec_func; state_nx = S_ALU_WB;
            end
            S_ALU_WB: begin
                rw = 1'b1; state_nx = S_FETCH;
            end
            S_MEM_ADR: begin
                src_a = SRCA_RS1; src_b = SRCB_IMM;
                state_nx = (bus.opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ:  begin adr = 1'b1; state_nx = S_MEM_WB; end
            S_MEM_WB:    begin res = RES_MEMDATA; rw = 1'b1; state_nx = S_FETCH; end
            S_MEM_WRITE: begin adr = 1'b1; mw = 1'b1; state_nx = S_FETCH; end
            S_BRANCH: begin
                src_a = SRCA_RS1; state_nx = S_FETCH;
                case (bus.funct3)
                    3'b000, 3'b001: func = ALU_SUB;
                    3'b100, 3'b101: func = ALU_SLT;
                    3'b110, 3'b111: func = ALU_SLTU;
                    default:        ill = 1'b1;
                endcase
                // beq/bge/bgeu take on zero, bne/blt/bltu on !zero
                pcw = !ill && (bus.zero ^ bus.funct3[2] ^ bus.funct3[0]);
            end
            S_JAL: begin
                pcw = 1'b1; state_nx = S_LINK;
            end
            S_JALR: begin
                src_a = SRCA_RS1; src_b = SRCB_IMM; res = RES_ALU; pcw = 1'b1;
                state_nx = S_LINK;
            end
            S_LINK: begin
                src_a = SRCA_OLDPC; src_b = SRCB_FOUR; res = RES_ALU; rw = 1'b1;
                state_nx = S_FETCH;
            end
            S_LUI: begin
                src_a = SRCA_ZERO; src_b = SRCB_IMM; res = RES_ALU; rw = 1'b1;
                state_nx = S_FETCH;
            end
            default: state_nx = S_FETCH;
        endcase
    end

    assign bus.alu_func   = func;
    assign bus.alu_src_a  = src_a;
    assign bus.alu_src_b  = src_b;
    assign bus.result_src = res;
    assign bus.imm_src    = imm_decode(bus.opcode);
    assign bus.adr_src    = adr;
    assign bus.ir_write   = irw & ~rst;
    assign bus.pc_write   = pcw & ~rst;
    assign bus.reg_write  = rw  & ~rst;
    assign bus.mem_write  = mw  & ~rst;
    assign bus.illegal    = ill & ~rst;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed scoreboard bench: per-cycle expected control words are queued before each
// instruction and compared on the falling edge.
module tb_multicycle_controller;

    typedef struct {
        string       tag;
        logic [18:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    multicycle_controller_if bus();

    multicycle_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // {func, src_a, src_b, result_src, imm_src, adr, ir_w, pc_w, reg_w, mem_w, illegal}
    task automatic e(input string tag, input logic [3:0] f, input logic [1:0] sa,
                     input logic [1:0] sb, input logic [1:0] rs, input logic [2:0] imm,
                     input logic adr, input logic irw, input logic pcw, input logic rw,
                     input logic mw, input logic ill);
        exp_t x;
        x.tag = tag;
        x.v   = {f, sa, sb, rs, imm, adr, irw, pcw, rw, mw, ill};
        q.push_back(x);
    endtask

    task automatic e_fetch(input logic [2:0] imm);
        e("fetch", 4'd0, 2'd0, 2'd2, 2'd2, imm, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic e_decode(input logic [2:0] imm, input logic ill);
        e("decode", 4'd0, 2'd1, 2'd1, 2'd0, imm, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ill);
    endtask

    task automatic check();
        exp_t        x;
        logic [18:0] obs;
        obs = {bus.alu_func, bus.alu_src_a, bus.alu_src_b, bus.result_src, bus.imm_src,
               bus.adr_src, bus.ir_write, bus.pc_write, bus.reg_write, bus.mem_write,
               bus.illegal};
        n_assert++;
        assert (q.size() != 0) else begin
            n_fail++;
            $error("FAIL scoreboard_underflow: observed %h with no expected entry", obs);
        end
        if (q.size() != 0) begin
            x = q.pop_front();
            n_assert++;
            assert (obs === x.v) else begin
                n_fail++;
                $error("FAIL %s: observed %b expected %b", x.tag, obs, x.v);
            end
        end
    endtask

    task automatic wait_chk(input int n);
        repeat (n) begin
            @(negedge clk);
            #1 check();
        end
    endtask

    task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                         input logic z, input int n);
        @(negedge clk);
        rst          = 1'b0;
        bus.opcode   = op;
        bus.funct3   = f3;
        bus.funct7_5 = f75;
        bus.zero     = z;
        #1 check();
        wait_chk(n - 1);
    endtask

    initial begin
        bus.opcode = 7'b0110011; bus.funct3 = 3'b000; bus.funct7_5 = 1'b0;
        bus.zero = 1'b0; bus.neg = 1'b0;
        @(posedge clk);
        // reset: FETCH datapath selects but every strobe held low
        e("reset0", 4'd0, 2'd0, 2'd2, 2'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e("reset1", 4'd0, 2'd0, 2'd2, 2'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_chk(2);

        // add
        e_fetch(3'd0); e_decode(3'd0, 1'b0);
        e("add_exec", 4'd0, 2'd2, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e("add_wb",   4'd0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        instr(7'b0110011, 3'b000, 1'b0, 1'b0, 4);

        // sub
        e_fetch(3'd0); e_decode(3'd0, 1'b0);
        e("sub_exec", 4'd1, 2'd2, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e("sub_wb",   4'd0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        instr(7'b0110011, 3'b000, 1'b1, 1'b0, 4);

        // and (R)
        e_fetch(3'd0); e_decode(3'd0, 1'b0);
        e("and_exec", 4'd2, 2'd2, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e("and_wb",   4'd0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        instr(7'b0110011, 3'b111, 1'b0, 1'b0, 4);

        // addi with bit 30 set must not subtract
        e_fetch(3'd0); e_decode(3'd0, 1'b0);
        e("addi_exec", 4'd0, 2'd2, 2'd1, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e("addi_wb",   4'd0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        instr(7'b0010011, 3'b000, 1'b1, 1'b0, 4);

        // sltiu
        e_fetch(3'd0); e_decode(3'd0, 1'b0);
        e("sltiu_exec", 4'd6, 2'd2, 2'd1, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e("sltiu_wb",   4'd0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        instr(7'b0010011, 3'b011, 1'b0, 1'b0, 4);

        // beq taken
        e_fetch(3'd2); e_decode(3'd2, 1'b0);
        e("beq_br", 4'd1, 2'd2, 2'd0, 2'd0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        instr(7'b1100011, 3'b000, 1'b0, 1'b1, 3);

        // bgeu not taken
        e_fetch(3'd2); e_decode(3'd2, 1'b0);
        e("bgeu_br", 4'd6, 2'd2, 2'd0, 2'd0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        instr(7'b1100011, 3'b111, 1'b0, 1'b0, 3);

        // blt taken on !zero
        e_fetch(3'd2); e_decode(3'd2, 1'b0);
        e("blt_br", 4'd5, 2'd2, 2'd0, 2'd0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        instr(7'b1100011, 3'b100, 1'b0, 1'b0, 3);

        // branch funct3 010: illegal, never taken
        e_fetch(3'd2); e_decode(3'd2, 1'b0);
        e("br010", 4'd0, 2'd2, 2'd0, 2'd0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        instr(7'b1100011, 3'b010, 1'b0, 1'b1, 3);

        // lw
        e_fetch(3'd0); e_decode(3'd0, 1'b0);
        e("lw_adr",  4'd0, 2'd2, 2'd1, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e("lw_read", 4'd0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e("lw_wb",   4'd0, 2'd0, 2'd0, 2'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        instr(7'b0000011, 3'b010, 1'b0, 1'b0, 5);

        // sw
        e_fetch(3'd1); e_decode(3'd1, 1'b0);
        e("sw_adr",   4'd0, 2'd2, 2'd1, 2'd0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e("sw_write", 4'd0, 2'd0, 2'd0, 2'd0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        instr(7'b0100011, 3'b010, 1'b0, 1'b0, 4);

        // jal
        e_fetch(3'd3); e_decode(3'd3, 1'b0);
        e("jal_jal",  4'd0, 2'd0, 2'd0, 2'd0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        e("jal_link", 4'd0, 2'd1, 2'd2, 2'd2, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        instr(7'b1101111, 3'b000, 1'b0, 1'b0, 4);

        // jalr
        e_fetch(3'd0); e_decode(3'd0, 1'b0);
        e("jalr_jalr", 4'd0, 2'd2, 2'd1, 2'd2, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        e("jalr_link", 4'd0, 2'd1, 2'd2, 2'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        instr(7'b1100111, 3'b000, 1'b0, 1'b0, 4);

        // lui
        e_fetch(3'd4); e_decode(3'd4, 1'b0);
        e("lui", 4'd0, 2'd3, 2'd1, 2'd2, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        instr(7'b0110111, 3'b000, 1'b0, 1'b0, 3);

        // unsupported opcode
        e_fetch(3'd0); e_decode(3'd0, 1'b1);
        instr(7'b0000000, 3'b000, 1'b0, 1'b0, 2);

        // lw interrupted by reset during MEM_READ
        e_fetch(3'd0); e_decode(3'd0, 1'b0);
        e("lwr_adr",  4'd0, 2'd2, 2'd1, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e("lwr_read", 4'd0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        instr(7'b0000011, 3'b010, 1'b0, 1'b0, 4);
        rst = 1'b1;
        e("rst_fetch", 4'd0, 2'd0, 2'd2, 2'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_chk(1);

        // restart cleanly with lui
        e_fetch(3'd4); e_decode(3'd4, 1'b0);
        e("lui2", 4'd0, 2'd3, 2'd1, 2'd2, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        instr(7'b0110111, 3'b000, 1'b0, 1'b0, 3);

        n_assert++;
        assert (q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_leftover: observed %0d entries expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
